mac_requant_drain: RTL and testbench

MAC_REQUANT_DRAIN -- requirements
Module: mac_requant_drain

---
 rtl/mac_requant_drain.sv | 174 +++++++++++++++++
 tb/tb_mac_requant_drain.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant_drain.sv
// Drains a packed MAC accumulator word lane by lane and emits each lane
// requantised to a saturated signed OUT_W value. The optional MAC_REQUANT_ROUND_EN
// macro enables round-half-up before the shift. Without it, the shift truncates.
module mac_requant_drain #(
    parameter int OUT_W   = 8,
    parameter int SHAMT_W = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [55:0]             acc_in,
    input  logic [1:0]              mode,
    input  logic [SHAMT_W-1:0]      shamt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [1:0]              out_lane,
    output logic                    out_last,
    output logic                    sat_flag
);

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    localparam logic signed [56:0] MAX_V = (57'sd1 <<< (OUT_W - 1)) - 57'sd1;
    localparam logic signed [56:0] MIN_V = -(57'sd1 <<< (OUT_W - 1));

    state_t               state_r, state_s;
    logic [55:0]          acc_r, acc_s;
    logic [1:0]           mode_r, mode_s;
    logic [1:0]           lane_r, lane_s;
    logic [SHAMT_W-1:0]   shamt_r, shamt_s;
    logic                 accept_s, xfer_s;

    logic                 out_valid_r, out_last_r, sat_flag_r;
    logic [1:0]           out_lane_r;
    logic [OUT_W-1:0]     out_data_r;
    logic                 valid_s, last_s, sat_s;
    logic [OUT_W-1:0]     data_s;
    logic signed [56:0]   lane_val_s, bias_s, shifted_s;

    function automatic logic signed [56:0] lane_extract(input logic [55:0] acc,
                                                        input logic [1:0]  md,
                                                        input logic [1:0]  ln);
        logic [27:0] w28;
        logic [13:0] w14;
        case (md)
            2'd1: begin
                w28 = ln[0] ? acc[55:28] : acc[27:0];
                return {{29{w28[27]}}, w28};
            end
            2'd2: begin
                case (ln)
                    2'd0:    w14 = acc[13:0];
                    2'd1:    w14 = acc[27:14];
                    2'd2:    w14 = acc[41:28];
                    default: w14 = acc[55:42];
                endcase
                return {{43{w14[13]}}, w14};
            end
            default: return {acc[55], acc};
        endcase
    endfunction

    function automatic logic [1:0] last_lane(input logic [1:0] md);
        case (md)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    assign accept_s  = in_valid & in_ready;
    assign xfer_s    = out_valid_r & out_ready;
    // out_last_r is only ever set while emitting, so it also qualifies EMIT here
    assign in_ready  = (state_r == IDLE) | (out_last_r & out_ready);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_lane  = out_lane_r;
    assign out_last  = out_last_r;
    assign sat_flag  = sat_flag_r;

    // State, holding registers and lane counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            acc_r   <= 56'd0;
            mode_r  <= 2'd0;
            lane_r  <= 2'd0;
            shamt_r <= '0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            mode_r  <= mode_s;
            lane_r  <= lane_s;
            shamt_r <= shamt_s;
        end
    end

    // Next-state: accept a word, step through lanes, or return to idle
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        mode_s  = mode_r;
        lane_s  = lane_r;
        shamt_s = shamt_r;
        if (accept_s) begin
            acc_s   = acc_in;
            mode_s  = mode;
            shamt_s = shamt;
            lane_s  = 2'd0;
            state_s = (mode == 2'd3) ? IDLE : EMIT;
        end else if (xfer_s) begin
            if (out_last_r) begin
                state_s = IDLE;
            end else begin
                lane_s = lane_r + 2'd1;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Output values for the lane presented next cycle, computed from next state
    always_comb begin
        lane_val_s = lane_extract(acc_s, mode_s, lane_s);
        bias_s     = 57'sd0;
`ifdef MAC_REQUANT_ROUND_EN
        if (shamt_s != '0) begin
            bias_s = 57'sd1 <<< (shamt_s - SHAMT_W'(1));
        end else begin
            bias_s = 57'sd0;
        end
`endif
        shifted_s = (lane_val_s + bias_s) >>> shamt_s;
        valid_s   = 1'b0;
        last_s    = 1'b0;
        sat_s     = 1'b0;
        data_s    = '0;
        if (state_s == EMIT) begin
            valid_s = 1'b1;
            last_s  = (lane_s == last_lane(mode_s));
            if (shifted_s > MAX_V) begin
                data_s = {1'b0, {(OUT_W-1){1'b1}}};
                sat_s  = 1'b1;
            end else if (shifted_s < MIN_V) begin
                data_s = {1'b1, {(OUT_W-1){1'b0}}};
                sat_s  = 1'b1;
            end else begin
                data_s = shifted_s[OUT_W-1:0];
            end
        end else begin
            valid_s = 1'b0;
        end
    end

    // Registered output stage; zero whenever no lane is presented
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_lane_r  <= 2'd0;
            out_last_r  <= 1'b0;
            sat_flag_r  <= 1'b0;
        end else begin
            out_valid_r <= valid_s;
            out_data_r  <= data_s;
            out_lane_r  <= valid_s ? lane_s : 2'd0;
            out_last_r  <= last_s;
            sat_flag_r  <= sat_s;
        end
    end

endmodule

// File: tb/tb_mac_requant_drain.sv
// Directed self-checking bench for mac_requant_drain.
// Beat vectors are {out_valid, out_lane[1:0], out_last, sat_flag, out_data[7:0]}.
module tb_mac_requant_drain;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [55:0]       acc_in;
    logic [1:0]        mode;
    logic [4:0]        shamt;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [1:0]        out_lane;
    logic              out_last;
    logic              sat_flag;

    int total = 0;
    int bad   = 0;

`ifdef MAC_REQUANT_ROUND_EN
    localparam logic [7:0] M0_POS = 8'd126;
    localparam logic [7:0] M0_NEG = 8'h83;
`else
    localparam logic [7:0] M0_POS = 8'd125;
    localparam logic [7:0] M0_NEG = 8'h82;
`endif

    mac_requant_drain #(.OUT_W(8), .SHAMT_W(5)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .acc_in(acc_in), .mode(mode), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
        .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; in_valid = 1'b0; acc_in = 56'd0; mode = 2'd0; shamt = 5'd0; out_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({out_valid, out_lane, out_last, sat_flag, out_data} !== 13'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", {out_valid, out_lane, out_last, sat_flag, out_data}, 13'd0);
        end
        step(); step();
        rstn = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_mode0();
        logic [12:0] got;
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 2'd0; acc_in = 56'd1004; shamt = 5'd3;
        step();
        in_valid = 1'b0;
        got = {out_valid, out_lane, out_last, sat_flag, out_data};
        total++;
        if (got !== {1'b1, 2'd0, 1'b1, 1'b0, M0_POS}) begin
            bad++; $display("FAIL mode0_pos got=%h exp=%h", got, {1'b1, 2'd0, 1'b1, 1'b0, M0_POS});
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'sd0) begin
            bad++; $display("FAIL mode0_idle got=%b/%h exp=0/00", out_valid, out_data);
        end
        in_valid = 1'b1; acc_in = 56'hFF_FFFF_FFFF_FC14; shamt = 5'd3;
        step();
        in_valid = 1'b0;
        got = {out_valid, out_lane, out_last, sat_flag, out_data};
        total++;
        if (got !== {1'b1, 2'd0, 1'b1, 1'b0, M0_NEG}) begin
            bad++; $display("FAIL mode0_neg got=%h exp=%h", got, {1'b1, 2'd0, 1'b1, 1'b0, M0_NEG});
        end
        in_valid = 1'b1; acc_in = 56'd1000000; shamt = 5'd2;
        step();
        in_valid = 1'b0;
        got = {out_valid, out_lane, out_last, sat_flag, out_data};
        total++;
        if (got !== {1'b1, 2'd0, 1'b1, 1'b1, 8'h7f}) begin
            bad++; $display("FAIL mode0_sat got=%h exp=%h", got, {1'b1, 2'd0, 1'b1, 1'b1, 8'h7f});
        end
        step();
    endtask

    task automatic test_mode2_sat();
        logic [12:0] exp_beats [4];
        logic [12:0] got;
        exp_beats[0] = {1'b1, 2'd0, 1'b0, 1'b0, 8'h05};
        exp_beats[1] = {1'b1, 2'd1, 1'b0, 1'b1, 8'h80};
        exp_beats[2] = {1'b1, 2'd2, 1'b0, 1'b1, 8'h7f};
        exp_beats[3] = {1'b1, 2'd3, 1'b1, 1'b0, 8'hff};
        out_ready = 1'b1;
        in_valid = 1'b1; mode = 2'd2; shamt = 5'd0;
        acc_in = {14'h3fff, 14'd300, 14'h2000, 14'd5};
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got = {out_valid, out_lane, out_last, sat_flag, out_data};
            total++;
            if (got !== exp_beats[i]) begin
                bad++; $display("FAIL mode2_beat%0d got=%h exp=%h", i, got, exp_beats[i]);
            end
            if (i == 3) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL mode2_last_in_ready got=%b exp=1", in_ready); end
            end
            step();
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mode2_done got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        logic [12:0] got;
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 2'd1; shamt = 5'd1;
        acc_in = {28'hfffffc0, 28'd64};
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {out_valid, out_lane, out_last, sat_flag, out_data};
            total++;
            if (got !== {1'b1, 2'd0, 1'b0, 1'b0, 8'h20} || in_ready !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%b exp=%h/0", i, got, in_ready, {1'b1, 2'd0, 1'b0, 1'b0, 8'h20});
            end
            step();
        end
        out_ready = 1'b1;
        got = {out_valid, out_lane, out_last, sat_flag, out_data};
        total++;
        if (got !== {1'b1, 2'd0, 1'b0, 1'b0, 8'h20}) begin
            bad++; $display("FAIL stall_lane0 got=%h exp=%h", got, {1'b1, 2'd0, 1'b0, 1'b0, 8'h20});
        end
        step();
        got = {out_valid, out_lane, out_last, sat_flag, out_data};
        total++;
        if (got !== {1'b1, 2'd1, 1'b1, 1'b0, 8'he0}) begin
            bad++; $display("FAIL stall_lane1 got=%h exp=%h", got, {1'b1, 2'd1, 1'b1, 1'b0, 8'he0});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_beats [4];
        logic        exp_rdy   [4];
        logic [12:0] got;
        exp_beats[0] = {1'b1, 2'd0, 1'b0, 1'b0, 8'h0a}; exp_rdy[0] = 1'b0;
        exp_beats[1] = {1'b1, 2'd1, 1'b1, 1'b0, 8'h14}; exp_rdy[1] = 1'b1;
        exp_beats[2] = {1'b1, 2'd0, 1'b0, 1'b0, 8'hfd}; exp_rdy[2] = 1'b0;
        exp_beats[3] = {1'b1, 2'd1, 1'b1, 1'b0, 8'h07}; exp_rdy[3] = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; mode = 2'd1; shamt = 5'd0;
        acc_in = {28'd20, 28'd10};
        step();
        acc_in = {28'd7, 28'hffffffd};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) in_valid = 1'b0;
            got = {out_valid, out_lane, out_last, sat_flag, out_data};
            total++;
            if (got !== exp_beats[i] || in_ready !== exp_rdy[i]) begin
                bad++; $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", i, got, in_ready, exp_beats[i], exp_rdy[i]);
            end
            step();
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; mode = 2'd2; shamt = 5'd0;
        acc_in = {14'd4, 14'd3, 14'd2, 14'd1};
        step();
        in_valid = 1'b0;
        step();
        step();
        total++;
        if (out_lane !== 2'd2 || out_data !== 8'sd3) begin
            bad++; $display("FAIL rmid_pre got=%0d/%0d exp=2/3", out_lane, out_data);
        end
        #1 rstn = 1'b0;
        #1;
        total++;
        if ({out_valid, out_lane, out_last, sat_flag, out_data} !== 13'd0) begin
            bad++; $display("FAIL rmid_async got=%h exp=%h", {out_valid, out_lane, out_last, sat_flag, out_data}, 13'd0);
        end
        #5 rstn = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_lane%0d got=%b exp=0", i, out_valid); end
            step();
        end
    endtask

    task automatic test_mode3();
        out_ready = 1'b1;
        in_valid = 1'b1; mode = 2'd3; shamt = 5'd0; acc_in = 56'd77;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mode3_drop got=%b/%b exp=0/1", out_valid, in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mode3_after got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode2_sat();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_mode3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
